dmem_handshake: RTL and testbench

DMEM_HANDSHAKE -- requirements
Module: dmem_handshake

---
 rtl/dmem_handshake.sv | 106 ++++++++++
 tb/tb_dmem_handshake.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_handshake.sv
// rtl/dmem_handshake.sv - single-request data memory with valid/ready request, wait-state FSM and one-cycle response
// The memory array is deliberately left out of reset so contents survive a core reset.
module dmem_handshake #(
    parameter int DEPTH = 64,
    parameter int WAIT  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic [31:0] mem [DEPTH];

    logic          accept;
    logic          access;
    logic          fault;
    logic [IW-1:0] widx;

    assign accept = req_valid && (state_q == ST_IDLE);
    assign access = (state_q == ST_WAIT) && (cnt_q == 4'd0);
    assign fault  = (addr_q[1:0] != 2'b00) || ({2'b00, addr_q[31:2]} >= 32'(DEPTH));
    assign widx   = addr_q[IW+1:2];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    state_d = ST_WAIT;
                    cnt_d   = 4'(WAIT);
                end
            end
            ST_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q    <= req_we;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (access) begin
                err_q   <= fault;
                rdata_q <= (!fault && !we_q) ? mem[widx] : 32'd0;
            end
        end
    end

    // A reset before the access edge returns the FSM to IDLE, so access is never seen.
    always_ff @(posedge clk) begin
        if (access && we_q && !fault) begin
            mem[widx] <= wdata_q;
        end
    end

    assign req_ready = !reset && (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_rdata = rsp_valid ? rdata_q : 32'd0;
    assign rsp_err   = rsp_valid && err_q;

endmodule

// File: tb/tb_dmem_handshake.sv
// tb/tb_dmem_handshake.sv - scoreboard bench driving a WAIT=2 and a WAIT=0 instance with random and directed requests
module tb_dmem_handshake;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  rv, rwe, rrdy, rspv, rerr, bsy;
    logic [31:0] raddr [2];
    logic [31:0] rwd   [2];
    logic [31:0] rrd   [2];

    always #5 clk = ~clk;

    dmem_handshake #(.DEPTH(DEPTH), .WAIT(2)) u_w2 (
        .clk(clk), .reset(reset),
        .req_valid(rv[0]), .req_ready(rrdy[0]), .req_we(rwe[0]),
        .req_addr(raddr[0]), .req_wdata(rwd[0]),
        .rsp_valid(rspv[0]), .rsp_rdata(rrd[0]), .rsp_err(rerr[0]), .busy(bsy[0])
    );

    dmem_handshake #(.DEPTH(DEPTH), .WAIT(0)) u_w0 (
        .clk(clk), .reset(reset),
        .req_valid(rv[1]), .req_ready(rrdy[1]), .req_we(rwe[1]),
        .req_addr(raddr[1]), .req_wdata(rwd[1]),
        .rsp_valid(rspv[1]), .rsp_rdata(rrd[1]), .rsp_err(rerr[1]), .busy(bsy[1])
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    logic [31:0] mm [2][DEPTH];
    int          acc [2];
    int          cyc    = 0;
    int          n_chk  = 0;
    int          n_fail = 0;

    function automatic int wt(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at cycle %0d", nm, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: timing comes from accept cycle + WAIT, data from the queue.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            bit   bexp;
            bit   vexp;
            bit   qempty;
            exp_t e;
            bexp = (cyc >= acc[d]) && (cyc < acc[d] + wt(d) + 2);
            vexp = (cyc == acc[d] + wt(d) + 1);
            chk($sformatf("busy[%0d]", d), 32'(bsy[d]), 32'(bexp));
            chk($sformatf("req_ready[%0d]", d), 32'(rrdy[d]), 32'(!reset && !bexp));
            chk($sformatf("rsp_valid[%0d]", d), 32'(rspv[d]), 32'(vexp));
            if (rspv[d] === 1'b1) begin
                qempty = (d == 0) ? (q0.size() == 0) : (q1.size() == 0);
                if (qempty) begin
                    chk($sformatf("unexpected_rsp[%0d]", d), 32'd1, 32'd0);
                end else begin
                    e = (d == 0) ? q0.pop_front() : q1.pop_front();
                    chk($sformatf("rsp_rdata[%0d]", d), rrd[d], e.rdata);
                    chk($sformatf("rsp_err[%0d]", d), 32'(rerr[d]), 32'(e.err));
                    chk($sformatf("rsp_cycle[%0d]", d), 32'(cyc), 32'(e.due));
                end
            end else begin
                chk($sformatf("idle_rdata[%0d]", d), rrd[d], 32'd0);
                chk($sformatf("idle_err[%0d]", d), 32'(rerr[d]), 32'd0);
            end
        end
    end

    task automatic issue(input int d, input bit we, input logic [31:0] addr,
                         input logic [31:0] wd, input bit hold, input bit abort);
        int   n;
        int   idx;
        bit   f;
        exp_t e;
        n = 0;
        while (rrdy[d] !== 1'b1 && n < 100) begin
            @(posedge clk); #2;
            n++;
        end
        if (rrdy[d] !== 1'b1) begin
            chk("ready_timeout", 32'd0, 32'd1);
            return;
        end
        rv[d] = 1'b1; rwe[d] = we; raddr[d] = addr; rwd[d] = wd;
        @(posedge clk); #1;
        acc[d] = cyc;
        f   = (addr[1:0] != 2'b00) || (addr[31:2] >= DEPTH);
        idx = int'(addr[7:2]);
        if (!abort) begin
            e.due   = cyc + wt(d) + 1;
            e.err   = f;
            e.rdata = 32'd0;
            if (!f) begin
                if (we) mm[d][idx] = wd;
                else    e.rdata = mm[d][idx];
            end
            if (d == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
        #1;
        if (hold) begin
            for (int i = 0; i < wt(d) + 2; i++) begin
                raddr[d] = $urandom; rwd[d] = $urandom; rwe[d] = 1'($urandom);
                @(posedge clk); #2;
            end
        end
        rv[d] = 1'b0; raddr[d] = $urandom; rwd[d] = $urandom; rwe[d] = 1'($urandom);
        if (abort) begin
            @(posedge clk); #2;
            reset  = 1'b1;
            acc[d] = -1000;
            @(posedge clk); #2;
            reset  = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q0.size() + q1.size()) != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        chk("drain_pending", 32'(q0.size() + q1.size()), 32'd0);
        repeat (3) @(posedge clk);
        #2;
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 9))
            0:       return 32'(($urandom_range(0, 63) << 2) | $urandom_range(1, 3));
            1:       return (($urandom | 32'h100) & ~32'h3);
            2:       return 32'h100;
            3:       return 32'hFC;
            default: return 32'($urandom_range(0, 63) << 2);
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        reset  = 1'b1;
        acc[0] = -1000;
        acc[1] = -1000;
        rv = 2'b00; rwe = 2'b00;
        for (int d = 0; d < 2; d++) begin
            raddr[d] = 32'd0;
            rwd[d]   = 32'd0;
        end
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;

        for (int d = 0; d < 2; d++)
            for (int w = 0; w < DEPTH; w++)
                issue(d, 1'b1, 32'(w << 2), $urandom, 1'b0, 1'b0);
        drain();

        issue(0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0);
        issue(0, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0);
        issue(1, 1'b1, 32'h0, 32'h00000007, 1'b0, 1'b0);
        issue(1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        for (int d = 0; d < 2; d++) begin
            issue(d, 1'b1, 32'h13, 32'hA5A5A5A5, 1'b0, 1'b0);
            issue(d, 1'b0, 32'h100, 32'h0, 1'b0, 1'b0);
            issue(d, 1'b0, 32'h4, 32'h0, 1'b0, 1'b0);
        end
        drain();

        issue(0, 1'b1, 32'h8, 32'h12345678, 1'b0, 1'b1);
        issue(0, 1'b0, 32'h8, 32'h0, 1'b0, 1'b0);
        drain();

        for (int d = 0; d < 2; d++) begin
            v = $urandom;
            issue(d, 1'b1, 32'h20, v, 1'b1, 1'b0);
            issue(d, 1'b0, 32'h20, 32'h0, 1'b1, 1'b0);
            issue(d, 1'b1, 32'hFC, ~v, 1'b0, 1'b0);
            issue(d, 1'b0, 32'hFC, 32'h0, 1'b0, 1'b0);
        end

        for (int i = 0; i < 150; i++)
            issue($urandom_range(0, 1), 1'($urandom), rand_addr(), $urandom,
                  ($urandom_range(0, 7) == 0), 1'b0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
